axis_stream_sink_ram: RTL and testbench

AXI4-Stream slave that receives one frame per arm and writes each beat into a BRAM-style destination memory at consecutive word addresses starting at 0.
It is the consumer stage for stream masters in the codebase, writing stream data back into on-chip memory.
A 2-entry skid FIFO decouples TREADY from the destination's write stall.
The block reports frame completion, beat count and address-space overflow.

---
 rtl/axis_stream_sink_ram_pkg.sv | 19 +
 rtl/axis_stream_sink_ram_if.sv | 25 ++
 rtl/axis_stream_sink_ram_fifo.sv | 77 +++++++
 rtl/axis_stream_sink_ram.sv | 165 ++++++++++++++++
 tb/tb_axis_stream_sink_ram.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_stream_sink_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_sink_pkg : state encodings and FIFO sizing for axis_stream_sink_ram |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package axis_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sink_state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/axis_stream_sink_ram_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_stream_sink_ram_if : AXI4-Stream beat channel with master/slave view |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface axis_stream_sink_ram_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32
);
    logic                                TREADY;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     TDATA;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   TSTRB;
    logic                                TLAST;
    logic                                TVALID;

    modport master (
        output TDATA, TSTRB, TLAST, TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA, TSTRB, TLAST, TVALID,
        output TREADY
    );
endinterface
`default_nettype wire

// File: rtl/axis_stream_sink_ram_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_skid_fifo2 : two-entry FIFO holding {data, strb, last} stream beats  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module axis_skid_fifo2
    import axis_sink_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic              clear_i,
    input  wire logic [DATA_W-1:0] data_i,
    input  wire logic [STRB_W-1:0] strb_i,
    input  wire logic              last_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [STRB_W-1:0]      head_strb_o,
    output logic                   head_last_o
);
    localparam int ENTRY_W = DATA_W + STRB_W + 1;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic [FIFO_CNT_W-1:0] count_d;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    assign {head_data_o, head_strb_o, head_last_o} = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear outranks a same-cycle push: the incoming beat is dropped too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= {data_i, strb_i, last_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/axis_stream_sink_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_stream_sink_ram : AXI4-Stream frame sink writing beats into a RAM    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module axis_stream_sink_ram
    import axis_sink_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int DST_ADDR_WIDTH       = 12
) (
    input  wire logic                                S_AXIS_ACLK,
    input  wire logic                                S_AXIS_ARESETN,
    axis_stream_sink_ram_if.slave                    s_axis,
    input  wire logic                                arm,
    output logic [DST_ADDR_WIDTH-1:0]                dst_addr,
    output logic                                     dst_wr_en,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]        dst_byte_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]          dst_data,
    input  wire logic                                dst_stall,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic [DST_ADDR_WIDTH:0]                  frame_beats,
    output logic                                     ovf_err
);
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
    localparam logic [DST_ADDR_WIDTH-1:0] ADDR_MAX = {DST_ADDR_WIDTH{1'b1}};
    localparam logic [DST_ADDR_WIDTH:0]   CAPACITY = {1'b1, {DST_ADDR_WIDTH{1'b0}}};

    sink_state_e               state_q, state_d;
    logic [DST_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                      last_seen_q, last_seen_d;
    logic                      ovf_q, ovf_d;
    logic [DST_ADDR_WIDTH:0]   frame_beats_q, frame_beats_d;

    logic                      w_tready;
    logic                      w_hs;
    logic                      w_wr_en;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_clear;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] w_head_data;
    logic [STRB_W-1:0]         w_head_strb;
    logic                      w_head_last;

    axis_skid_fifo2 #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH),
        .STRB_W (STRB_W)
    ) u_fifo (
        .clk         (S_AXIS_ACLK),
        .rst_n       (S_AXIS_ARESETN),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .clear_i     (w_clear),
        .data_i      (s_axis.TDATA),
        .strb_i      (s_axis.TSTRB),
        .last_i      (s_axis.TLAST),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_data_o (w_head_data),
        .head_strb_o (w_head_strb),
        .head_last_o (w_head_last)
    );

    assign w_hs = s_axis.TVALID && w_tready;

    // TREADY depends only on state, FIFO occupancy and last_seen registers.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        last_seen_d   = last_seen_q;
        ovf_d         = ovf_q;
        frame_beats_d = frame_beats_q;
        w_tready      = 1'b0;
        w_wr_en       = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_clear       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_RECV;
                    wr_addr_d   = '0;
                    last_seen_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end

            ST_RECV: begin
                w_tready = !w_fifo_full && !last_seen_q;
                w_push   = w_hs;
                if (w_hs && s_axis.TLAST) begin
                    last_seen_d = 1'b1;
                end

                w_wr_en = !w_fifo_empty && !dst_stall;
                w_pop   = w_wr_en;

                if (w_wr_en) begin
                    if (w_head_last) begin
                        state_d       = ST_DONE;
                        frame_beats_d = {1'b0, wr_addr_q} + (DST_ADDR_WIDTH+1)'(1);
                    end else if (wr_addr_q == ADDR_MAX) begin
                        // Capacity reached mid-frame: drop the rest of it.
                        ovf_d         = 1'b1;
                        frame_beats_d = CAPACITY;
                        w_clear       = 1'b1;
                        if (last_seen_q || (w_hs && s_axis.TLAST)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + DST_ADDR_WIDTH'(1);
                    end
                end
            end

            ST_FLUSH: begin
                w_tready = 1'b1;
                if (s_axis.TVALID && s_axis.TLAST) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            last_seen_q   <= 1'b0;
            ovf_q         <= 1'b0;
            frame_beats_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            last_seen_q   <= last_seen_d;
            ovf_q         <= ovf_d;
            frame_beats_q <= frame_beats_d;
        end
    end

    assign s_axis.TREADY = w_tready;
    assign dst_wr_en     = w_wr_en;
    assign dst_addr      = wr_addr_q;
    assign dst_data      = w_head_data;
    assign dst_byte_en   = w_head_strb;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_DONE);
    assign frame_beats   = frame_beats_q;
    assign ovf_err       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_axis_stream_sink_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_stream_sink_ram : directed frame vectors for the stream RAM sink  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_axis_stream_sink_ram;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          dst_stall;
    logic [AW-1:0] dst_addr;
    logic          dst_wr_en;
    logic [SW-1:0] dst_byte_en;
    logic [DW-1:0] dst_data;
    logic          busy;
    logic          frame_done;
    logic [AW:0]   frame_beats;
    logic          ovf_err;

    axis_stream_sink_ram_if #(.C_S_AXIS_TDATA_WIDTH(DW)) s_axis ();

    axis_stream_sink_ram #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .DST_ADDR_WIDTH       (AW)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .s_axis         (s_axis.slave),
        .arm            (arm),
        .dst_addr       (dst_addr),
        .dst_wr_en      (dst_wr_en),
        .dst_byte_en    (dst_byte_en),
        .dst_data       (dst_data),
        .dst_stall      (dst_stall),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_beats    (frame_beats),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int            cyc;
    } wr_t;

    typedef struct {
        int            n;
        logic [DW-1:0] base;
        int            stall;
        int            exp_wr;
        int            exp_beats;
        int            exp_ovf;
        int            exp_lo;
        int            exp_lat;
    } vec_t;

    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  fd_cnt     = 0;
    int  lo_cnt     = 0;
    int  arm_cyc    = 0;
    bit  abort      = 1'b0;
    wr_t wq[$];
    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dst_wr_en) wq.push_back('{dst_addr, dst_data, dst_byte_en, cyc});
        if (frame_done) fd_cnt++;
        if (s_axis.TVALID && !s_axis.TREADY && busy) lo_cnt++;
        if (arm) arm_cyc = cyc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [SW-1:0] beat_strb(input int i);
        return 4'hF ^ i[3:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int wt;
            bit got;
            wt  = 0;
            got = 1'b0;
            s_axis.TVALID = 1'b1;
            s_axis.TDATA  = base + DW'(i);
            s_axis.TSTRB  = beat_strb(i);
            s_axis.TLAST  = (i == n - 1);
            while (!got && wt < 200 && !abort) begin
                @(negedge clk);
                got = s_axis.TREADY;
                wt++;
            end
            if (abort) break;
            if (!got) begin
                timeout_fail("send_handshake");
                break;
            end
            @(posedge clk); #1;
        end
        s_axis.TVALID = 1'b0;
        s_axis.TLAST  = 1'b0;
    endtask

    task automatic stall_drv(input int ncyc);
        int wt;
        if (ncyc > 0) begin
            wt = 0;
            do begin
                @(negedge clk);
                wt++;
            end while (!(s_axis.TVALID && s_axis.TREADY) && wt < 100);
            @(posedge clk); #1 dst_stall = 1'b1;
            repeat (ncyc) @(posedge clk);
            #1 dst_stall = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int wt;
        wt = 0;
        do begin
            @(negedge clk);
            wt++;
        end while (!frame_done && wt < 200);
        if (!frame_done) timeout_fail(name);
    endtask

    initial begin
        // n, base, stall, writes, frame_beats, ovf, tready-low cycles, latency
        vt[0] = '{4, 32'hA0, 0, 4, 4, 0, 0, 2};
        vt[1] = '{4, 32'hA0, 5, 4, 4, 0, 5, -1};
        vt[2] = '{1, 32'hB0, 0, 1, 1, 0, 0, 2};
        vt[3] = '{3, 32'hC0, 0, 3, 3, 0, 0, 2};
        vt[4] = '{7, 32'hD0, 0, 4, 4, 1, 0, 2};

        rst_n         = 1'b0;
        arm           = 1'b0;
        dst_stall     = 1'b0;
        s_axis.TVALID = 1'b0;
        s_axis.TDATA  = '0;
        s_axis.TSTRB  = '0;
        s_axis.TLAST  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 64'(s_axis.TREADY), 0);
        check("rst_wr_en", 64'(dst_wr_en), 0);
        check("rst_frame_done", 64'(frame_done), 0);
        check("rst_frame_beats", 64'(frame_beats), 0);
        check("rst_ovf", 64'(ovf_err), 0);
        check("rst_busy", 64'(busy), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            wq.delete();
            fd_cnt = 0;
            lo_cnt = 0;
            pulse_arm();
            fork
                send_beats(vt[k].n, vt[k].base);
                stall_drv(vt[k].stall);
            join
            wait_done("frame_done_wait");
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_nwrites", k), 64'(wq.size()), 64'(vt[k].exp_wr));
            for (int j = 0; j < wq.size() && j < vt[k].exp_wr; j++) begin
                check($sformatf("v%0d_addr%0d", k, j), 64'(wq[j].addr), 64'(j));
                check($sformatf("v%0d_data%0d", k, j), 64'(wq[j].data), 64'(vt[k].base + DW'(j)));
                check($sformatf("v%0d_strb%0d", k, j), 64'(wq[j].strb), 64'(beat_strb(j)));
            end
            if (vt[k].exp_lat >= 0 && wq.size() > 0)
                check($sformatf("v%0d_latency", k), 64'(wq[0].cyc - arm_cyc), 64'(vt[k].exp_lat));
            check($sformatf("v%0d_frame_beats", k), 64'(frame_beats), 64'(vt[k].exp_beats));
            check($sformatf("v%0d_ovf", k), 64'(ovf_err), 64'(vt[k].exp_ovf));
            check($sformatf("v%0d_tready_low", k), 64'(lo_cnt), 64'(vt[k].exp_lo));
            check($sformatf("v%0d_done_pulses", k), 64'(fd_cnt), 1);
            check($sformatf("v%0d_busy_after", k), 64'(busy), 0);
        end

        // Overflow flag is sticky while idle.
        repeat (5) @(posedge clk);
        #1 check("ovf_sticky", 64'(ovf_err), 1);

        // Pending beat while IDLE is not taken until armed; arm in DONE is ignored.
        begin
            int hi_cnt;
            hi_cnt = 0;
            wq.delete();
            fd_cnt = 0;
            s_axis.TVALID = 1'b1;
            s_axis.TLAST  = 1'b1;
            s_axis.TDATA  = 32'h55;
            s_axis.TSTRB  = 4'hF;
            repeat (10) begin
                @(negedge clk);
                if (s_axis.TREADY) hi_cnt++;
            end
            check("idle_tready_high", 64'(hi_cnt), 0);
            check("idle_no_writes", 64'(wq.size()), 0);
            fork
                begin
                    pulse_arm();
                    send_beats(1, 32'h55);
                end
                begin
                    @(negedge clk);
                    check("frame_beats_held", 64'(frame_beats), 4);
                    wait_done("one_beat_done");
                    arm = 1'b1;
                    @(posedge clk); #1 arm = 1'b0;
                    @(negedge clk);
                    check("arm_in_done_ignored", 64'(busy), 0);
                end
            join
            repeat (2) @(posedge clk);
            #1;
            check("one_nwrites", 64'(wq.size()), 1);
            if (wq.size() > 0) begin
                check("one_addr", 64'(wq[0].addr), 0);
                check("one_data", 64'(wq[0].data), 32'h55);
            end
            check("one_frame_beats", 64'(frame_beats), 1);
            check("one_ovf_cleared", 64'(ovf_err), 0);
        end

        // Reset pulsed mid-frame after two writes.
        wq.delete();
        fd_cnt = 0;
        pulse_arm();
        fork
            send_beats(4, 32'hE0);
            begin
                int wt;
                wt = 0;
                do begin
                    @(negedge clk); #1;
                    wt++;
                end while (wq.size() < 2 && wt < 50);
                if (wq.size() < 2) timeout_fail("two_writes_wait");
                #2 rst_n = 1'b0;
                #1;
                check("arst_tready", 64'(s_axis.TREADY), 0);
                check("arst_wr_en", 64'(dst_wr_en), 0);
                check("arst_busy", 64'(busy), 0);
                check("arst_frame_beats", 64'(frame_beats), 0);
                abort = 1'b1;
                s_axis.TVALID = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_done", 64'(fd_cnt), 0);
        rst_n = 1'b1;
        abort = 1'b0;
        wq.delete();
        pulse_arm();
        send_beats(2, 32'hF0);
        wait_done("post_reset_done");
        repeat (2) @(posedge clk);
        #1;
        check("post_nwrites", 64'(wq.size()), 2);
        if (wq.size() > 0) begin
            check("post_addr0", 64'(wq[0].addr), 0);
            check("post_data0", 64'(wq[0].data), 32'hF0);
        end
        check("post_frame_beats", 64'(frame_beats), 2);
        check("post_ovf", 64'(ovf_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
